psg_tone_bank: RTL
==================

// Module: psg_tone_bank
// PURPOSE
//  Multi-channel PSG tone generator with NUM_CH independent channels.
//  - Each channel holds a frequency code, a wave mode (triangle/square) and a 4-bit attenuation.
//  - One shared serial divider converts each frequency code to a per-sample step (DIVIDEND/freq).
//  - Outputs are mixed into one saturated signed sample per sample_tick, feeding the audio output path.
// PARAMETERS
//  NUM_CH    3       number of tone channels (>=1)
//  FREQ_W    10      frequency code width
//  OUT_W     16      signed sample / accumulator width
//  DIVIDEND  152727  step numerator; DIV_W = $clog2(DIVIDEND+1) = 18
// PORTS
//  clk         in   1                clock
//  reset       in   1                asynchronous, active-high
//  cfg_valid   in   1                config write request
//  cfg_ready   out  1                config write accepted when cfg_valid & cfg_ready
//  cfg_ch      in   CH_W=$clog2(NUM_CH)  target channel (minimum width 1)
//  cfg_freq    in   FREQ_W           frequency code; 0 = channel muted
//  cfg_mode    in   1                0 = triangle, 1 = square
//  cfg_atten   in   4                right-shift amount; 15 = mute
//  sample_tick in   1                advance all channels one sample
//  sample_out  out  OUT_W (signed)   mixed sample
//  sample_valid out 1                1-cycle pulse, sample_out updated
//  ch_busy     out  NUM_CH           bit i = divide pending for channel i
// BEHAVIOUR
//  Reset state:
//  - cfg_ready=1, sample_out=0, sample_valid=0, ch_busy=0.
//  - Every channel: step=0, acc=0, dir=up, pol=+, atten=15, mode=triangle.
//  - Reset mid-divide aborts the divide; no step is written.
//  Config write (accept at edge N):
//  - mode and atten are written at edge N.
//  - freq==0: step<=0 at edge N; cfg_ready stays 1.
//  - freq!=0: cfg_ready=0 and ch_busy[ch]=1 from N.
//    - Restoring divide runs for DIV_W cycles, MSB first.
//    - step <= min(quotient, 2^(OUT_W-1)-1) at edge N+DIV_W.
//    - cfg_ready=1 and ch_busy[ch]=0 from edge N+DIV_W onward.
//  - cfg_ch>=NUM_CH: accepted, dropped, no divide.
//  Channel advance on sample_tick (MAX = 2^(OUT_W-1)-1):
//  - If a step write and sample_tick fall in the same cycle, the tick uses the old step.
//  - Triangle, dir=up: if acc+step>MAX then acc<=MAX and dir<=down, else acc+=step.
//  - Triangle, dir=down: if acc-step<-MAX then acc<=-MAX and dir<=up, else acc-=step.
//  - Square: unsigned OUT_W phase += step. On carry-out pol toggles; value = pol ? -MAX : +MAX.
//  - step==0: triangle holds; square value is forced to 0.
//  - Changing mode clears acc, phase, dir and pol.
//  Mix:
//  - Each channel contributes (value >>> atten); atten 15 contributes 0.
//  - Sum width is OUT_W+$clog2(NUM_CH+1); the sum saturates to [-MAX-1, MAX].
//  - sample_out is registered at edge T+1 for a tick at edge T; sample_valid=1 for that cycle only.
//  - Back-to-back ticks give back-to-back samples.
// STRUCTURE
//  psg_pkg:
//  - wave_mode_t enum {WAVE_TRI, WAVE_SQR}.
//  - Constants DIVIDEND, ATT_MUTE=4'hF.
//  - Function sat_to_out().
//  Sub-module psg_serial_div: start, numerator, denominator, busy, done, quotient; DIV_W-cycle latency.
//  Channel state lives in packed arrays inside psg_tone_bank.
// TESTING
//  1. Write ch0 freq=100, tri, atten=0 -> cfg_ready low for 18 cycles, step=1527; 3 ticks -> 1527, 3054, 4581.
//  2. freq=1 -> step saturates to 32767. freq=1023 -> step=149.
//  3. ch1 sqr, freq=9 (step 16969): 4 ticks -> carry on tick 4, output flips +32767 -> -32767.
//  4. All 3 channels sqr, pol +, atten 0 -> sum 98301 saturates to 32767; atten 2 each -> 24573.
//  5. Assert reset 5 cycles into a divide -> cfg_ready=1, ch_busy=0, step stays 0, sample_out=0.
//  6. Tri at acc=32000, step=1527 on tick -> acc=32767, dir=down; next tick -> 31240. freq=0 write -> immediate ready, output held.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared types, constants and helpers for the PSG tone bank.
package psg_pkg;

  typedef enum logic {
    WAVE_TRI = 1'b0,
    WAVE_SQR = 1'b1
  } wave_mode_t;

  // Numerator of the frequency-code to per-sample step conversion.
  localparam int DIVIDEND = 152727;

  // Attenuation code that silences a channel outright.
  localparam logic [3:0] ATT_MUTE = 4'hF;

  // Clamp a signed value into the signed range of an out_w-bit sample.
  function automatic logic signed [31:0] sat_to_out(input logic signed [31:0] value,
                                                    input int out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/psg_serial_div.sv
// Restoring serial divider, one quotient bit per cycle, MSB first.
// The first iteration runs on the start edge, so the finished quotient is
// registered NUM_W-1 edges later and done pulses for the following cycle.
module psg_serial_div #(
  parameter int NUM_W = 18,
  parameter int DEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [NUM_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [DEN_W-1:0] src_rem;
  logic [NUM_W-1:0] src_quo;
  logic [DEN_W-1:0] src_den;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   trial;
  logic             trial_msb_unused;
  logic             fits;
  logic [DEN_W-1:0] nxt_rem;
  logic [NUM_W-1:0] nxt_quo;

  // One restoring step: shift in the next numerator bit and subtract if it fits.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    src_rem = start ? '0 : rem_q;
    src_quo = start ? numerator : quo_q;
    src_den = start ? denominator : den_q;
    shifted = {src_rem, src_quo[NUM_W-1]};
    fits    = (shifted >= {1'b0, src_den});
    trial   = shifted - {1'b0, src_den};
    // The remainder is always below the divisor, so the top bit is never needed.
    trial_msb_unused = trial[DEN_W];
    nxt_rem = fits ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];
    nxt_quo = {src_quo[NUM_W-2:0], fits};
  end

  // Iteration counter, partial remainder and quotient shift register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      den_q  <= denominator;
      rem_q  <= nxt_rem;
      quo_q  <= nxt_quo;
      cnt_q  <= CNT_W'(NUM_W - 1);
      done_q <= (NUM_W == 1);
    end else if (cnt_q != '0) begin
      rem_q  <= nxt_rem;
      quo_q  <= nxt_quo;
      cnt_q  <= cnt_q - CNT_W'(1);
      done_q <= (cnt_q == CNT_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/psg_tone_bank.sv
// Multi-channel PSG tone generator: per-channel triangle/square oscillators,
// one shared serial divider for frequency-to-step conversion, saturating mix.
module psg_tone_bank
  import psg_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int FREQ_W   = 10,
  parameter int OUT_W    = 16,
  parameter int DIVIDEND = psg_pkg::DIVIDEND,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DIV_W   = $clog2(DIVIDEND + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [FREQ_W-1:0]       cfg_freq,
  input  logic                    cfg_mode,
  input  logic [3:0]              cfg_atten,
  input  logic                    sample_tick,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic [NUM_CH-1:0]       ch_busy
);

  localparam int SUM_W = OUT_W + $clog2(NUM_CH + 1);
  localparam int MAX_I = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [OUT_W-1:0] MAX_V   = OUT_W'(MAX_I);
  localparam logic signed [OUT_W-1:0] MIN_V   = -MAX_V;
  localparam logic signed [OUT_W-1:0] ZERO_V  = '0;
  localparam logic signed [OUT_W:0]   MAX_EXT = (OUT_W + 1)'(MAX_I);
  localparam logic signed [OUT_W:0]   MIN_EXT = -MAX_EXT;

  // Per-channel state. acc_q is the signed level in triangle mode and the
  // unsigned phase in square mode; dir_q 1 = falling, pol_q 1 = negative.
  logic       [NUM_CH-1:0][OUT_W-1:0] step_q;
  logic       [NUM_CH-1:0][OUT_W-1:0] acc_q;
  logic       [NUM_CH-1:0]            dir_q;
  logic       [NUM_CH-1:0]            pol_q;
  logic       [NUM_CH-1:0][3:0]       atten_q;
  wave_mode_t [NUM_CH-1:0]            mode_q;

  logic [NUM_CH-1:0][OUT_W-1:0] nxt_acc;
  logic [NUM_CH-1:0]            nxt_dir;
  logic [NUM_CH-1:0]            nxt_pol;
  logic signed [OUT_W:0]        up_sum [NUM_CH];
  logic signed [OUT_W:0]        dn_dif [NUM_CH];
  logic [OUT_W:0]               ph_sum [NUM_CH];
  logic signed [OUT_W-1:0]      ch_val [NUM_CH];
  logic signed [OUT_W-1:0]      ch_contrib [NUM_CH];
  logic signed [SUM_W-1:0]      mix_sum;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_quot;
  logic             div_pending;
  logic [CH_W-1:0]  pend_ch_q;
  logic [OUT_W-1:0] step_wr;
  logic             cfg_hit;
  logic             tick_q;

  assign div_pending = div_busy | div_done;
  assign cfg_ready   = ~div_pending;
  assign ch_busy     = div_pending ? (NUM_CH'(1) << pend_ch_q) : '0;
  assign cfg_hit     = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);
  assign div_start   = cfg_hit && (cfg_freq != '0);
  assign step_wr     = (32'(div_quot) > MAX_I) ? OUT_W'(MAX_I) : OUT_W'(div_quot);

  psg_serial_div #(
    .NUM_W(DIV_W),
    .DEN_W(FREQ_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start      (div_start),
    .numerator  (DIV_W'(DIVIDEND)),
    .denominator(cfg_freq),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_quot)
  );

  // Oscillator advance for every channel on sample_tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      up_sum[i]  = $signed({acc_q[i][OUT_W-1], acc_q[i]}) + $signed({1'b0, step_q[i]});
      dn_dif[i]  = $signed({acc_q[i][OUT_W-1], acc_q[i]}) - $signed({1'b0, step_q[i]});
      ph_sum[i]  = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
      nxt_acc[i] = acc_q[i];
      nxt_dir[i] = dir_q[i];
      nxt_pol[i] = pol_q[i];
      if (sample_tick) begin
        if (mode_q[i] == WAVE_SQR) begin
          nxt_acc[i] = ph_sum[i][OUT_W-1:0];
          if (ph_sum[i][OUT_W]) nxt_pol[i] = ~pol_q[i];
        end else if (!dir_q[i]) begin
          if (up_sum[i] > MAX_EXT) begin
            nxt_acc[i] = MAX_V;
            nxt_dir[i] = 1'b1;
          end else begin
            nxt_acc[i] = up_sum[i][OUT_W-1:0];
          end
        end else begin
          if (dn_dif[i] < MIN_EXT) begin
            nxt_acc[i] = MIN_V;
            nxt_dir[i] = 1'b0;
          end else begin
            nxt_acc[i] = dn_dif[i][OUT_W-1:0];
          end
        end
      end
    end
  end

  // Per-channel output level, attenuation and wide signed sum.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode_q[i] == WAVE_SQR) begin
        if (step_q[i] == '0)  ch_val[i] = ZERO_V;
        else if (pol_q[i])    ch_val[i] = MIN_V;
        else                  ch_val[i] = MAX_V;
      end else begin
        ch_val[i] = $signed(acc_q[i]);
      end
      // An arithmetic shift of a negative level never reaches 0, so mute explicitly.
      if (atten_q[i] == ATT_MUTE) ch_contrib[i] = ZERO_V;
      else                        ch_contrib[i] = ch_val[i] >>> atten_q[i];
      mix_sum = mix_sum + SUM_W'(ch_contrib[i]);
    end
  end

  // Channel state, config writes, divide write-back and sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q       <= '0;
      acc_q        <= '0;
      dir_q        <= '0;
      pol_q        <= '0;
      pend_ch_q    <= '0;
      tick_q       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        atten_q[i] <= ATT_MUTE;
        mode_q[i]  <= WAVE_TRI;
      end
    end else begin
      acc_q <= nxt_acc;
      dir_q <= nxt_dir;
      pol_q <= nxt_pol;

      if (div_done) step_q[pend_ch_q] <= step_wr;

      // Config overrides the tick update; the tick itself still used the old step.
      if (cfg_hit) begin
        atten_q[cfg_ch] <= cfg_atten;
        mode_q[cfg_ch]  <= wave_mode_t'(cfg_mode);
        if (wave_mode_t'(cfg_mode) != mode_q[cfg_ch]) begin
          acc_q[cfg_ch] <= '0;
          dir_q[cfg_ch] <= 1'b0;
          pol_q[cfg_ch] <= 1'b0;
        end
        if (cfg_freq == '0) step_q[cfg_ch] <= '0;
        else                pend_ch_q      <= cfg_ch;
      end

      tick_q       <= sample_tick;
      sample_valid <= tick_q;
      if (tick_q) sample_out <= OUT_W'(sat_to_out(32'(mix_sum), OUT_W));
    end
  end

endmodule
